// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Serialises host bitstream words onto the configuration flip-flop chain of a
// logic tile (frac_logic config -> mem_fabric_out_0 -> mem_fabric_out_1) and
// qualifies every programming-clock shift with shift_en.
// Build option: define CCFF_READBACK_EN to run a second pass in which the
// resent bitstream is compared against what falls out of ccff_tail.
//
// state | meaning
// IDLE  | waiting for cfg_start; all outputs low
// FETCH | waiting for a host word; cfg_ready=1, chain frozen
// SHIFT | one bit per cycle onto ccff_head with shift_en=1
// FIN   | one-cycle done pulse, then back to IDLE
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

`ifdef CCFF_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              pass_q, pass_d;
  logic              err_q, err_d;

  logic              pass_last;
  logic              word_last;

  // The bit counter is compared for equality, so it never needs to wrap.
  assign pass_last = (bit_cnt_q == LAST_CNT);
  assign word_last = (bit_idx_q == LAST_IDX);

  // State register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pass completion takes priority over word exhaustion so
  // leftover bits of the final word are simply dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (cfg_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (pass_last) begin
          state_d = (READBACK && !pass_q) ? S_FETCH : S_FIN;
        end else if (word_last) begin
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; ccff_head is forced low whenever the chain is not advancing
  always_comb begin
    cfg_ready = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ccff_head = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_FETCH: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      S_SHIFT: begin
        shift_en  = 1'b1;
        busy      = 1'b1;
        ccff_head = word_q[bit_idx_q];
      end
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath next-state: word capture, bit index, pass counter, readback flag
  always_comb begin
    word_d    = word_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    pass_d    = pass_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          bit_cnt_d = '0;
          pass_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_FETCH: begin
        if (cfg_valid) begin
          word_d    = cfg_data;
          bit_idx_d = '0;
        end
      end
      S_SHIFT: begin
        bit_idx_d = bit_idx_q + 1'b1;
        // ccff_tail still carries the bit shifted CHAIN_LEN edges ago, which
        // in pass two is the same bit index from pass one.
        if (READBACK && pass_q && (ccff_tail != ccff_head)) begin
          err_d = 1'b1;
        end
        if (pass_last) begin
          bit_cnt_d = '0;
          if (READBACK) pass_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      word_q    <= '0;
      bit_idx_q <= '0;
      bit_cnt_q <= '0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      word_q    <= word_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

  // Without readback err_q never leaves its reset value, so this is a tie-off.
  assign cfg_err = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int CNT_W     = 16;
  localparam int WPP       = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_READBACK_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int MAXW   = WPP * NPASS;
  localparam int LOG_SZ = 8192;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b1;
  logic              cfg_start = 1'b0;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready, ccff_head, ccff_tail, shift_en, busy, done, cfg_err;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .cfg_start(cfg_start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: the tile's chain, shifting on every qualified edge.
  logic [CHAIN_LEN-1:0] env_chain = '0;
  assign ccff_tail = env_chain[CHAIN_LEN-1];
  always @(posedge prog_clk) if (shift_en) env_chain <= {env_chain[CHAIN_LEN-2:0], ccff_head};

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Reference model: a queue of bits still owed to the chain plus a count of
  // bits left in the current pass.
  bit   m_active = 1'b0;
  bit   m_fin    = 1'b0;
  int   m_pass   = 0;
  int   m_left   = 0;
  bit   m_err    = 1'b0;
  logic bitq[$];

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      m_active = 1'b0; m_fin = 1'b0; m_pass = 0; m_left = 0; m_err = 1'b0;
      bitq.delete();
    end else if (m_fin) begin
      m_fin = 1'b0; m_active = 1'b0;
    end else if (!m_active) begin
      if (cfg_start) begin
        m_active = 1'b1; m_pass = 0; m_left = CHAIN_LEN; m_err = 1'b0;
      end
    end else if (bitq.size() > 0) begin
      if (NPASS == 2 && m_pass == 1 && ccff_tail != bitq[0]) m_err = 1'b1;
      void'(bitq.pop_front());
      m_left--;
      if (m_left == 0) begin
        if (NPASS == 2 && m_pass == 0) begin
          m_pass = 1; m_left = CHAIN_LEN;
        end else begin
          m_fin = 1'b1;
        end
      end
    end else if (cfg_valid) begin
      for (int b = 0; b < WORD_W && b < m_left; b++) bitq.push_back(cfg_data[b]);
    end
  end

  // Per-cycle compare against the model, plus bookkeeping for scenario checks.
  int   shifts_total = 0;
  int   dones_total  = 0;
  int   err_rise_at  = -1000;
  logic err_prev     = 1'b0;
  logic bits_log [LOG_SZ];
  logic e_shift, e_head;

  always @(negedge prog_clk) begin
    e_shift = (bitq.size() > 0);
    e_head  = e_shift ? bitq[0] : 1'b0;
    chk("cyc_busy",     busy,      m_active && !m_fin);
    chk("cyc_ready",    cfg_ready, m_active && !m_fin && !e_shift);
    chk("cyc_shift_en", shift_en,  e_shift);
    chk("cyc_head",     ccff_head, e_head);
    chk("cyc_done",     done,      m_fin);
    chk("cyc_err",      cfg_err,   m_err);
    if (cfg_err && !err_prev) err_rise_at = shifts_total;
    err_prev = cfg_err;
    if (shift_en) begin
      if (shifts_total < LOG_SZ) bits_log[shifts_total] = ccff_head;
      shifts_total++;
    end
    if (done) dones_total++;
  end

  logic [WORD_W-1:0] seq_w   [MAXW];
  int                seq_gap [MAXW];

  function automatic logic [31:0] log_vec(input int base);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < CHAIN_LEN; k++) v[k] = bits_log[base + k];
    return v;
  endfunction

  function automatic logic [31:0] exp_vec(input int p);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < CHAIN_LEN; k++) v[k] = seq_w[p * WPP + k / WORD_W][k % WORD_W];
    return v;
  endfunction

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (cfg_ready !== 1'b1 && t < 300) begin
      @(posedge prog_clk); @(negedge prog_clk);
      cfg_start = 1'b0;
      t++;
    end
    ok = (cfg_ready === 1'b1);
    if (!ok) chk("ready_timeout", cfg_ready, 1);
  endtask

  // Runs one full sequence from the driver's view; called at a negedge.
  task automatic run_seq(input int nw, input int poke, output int lat,
                         output int sh_d, output int dn_d, output int sh0, output int er_d);
    int  t, dn0, start_cyc;
    bit  ok;
    lat = -1;
    cfg_start = 1'b1;
    @(posedge prog_clk);
    sh0 = shifts_total; dn0 = dones_total;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    start_cyc = cyc;
    chk("err_clear_on_start", cfg_err, 0);
    ok = 1'b1;
    for (int i = 0; i < nw && ok; i++) begin
      if (seq_gap[i] > 0) begin
        cfg_valid = 1'b0;
        wait_ready(ok);
        for (int g = 0; g < seq_gap[i] && ok; g++) begin
          chk("stall_ready", cfg_ready, 1);
          chk("stall_shift_en", shift_en, 0);
          @(posedge prog_clk); @(negedge prog_clk);
        end
      end
      cfg_data = seq_w[i]; cfg_valid = 1'b1;
      if (ok) wait_ready(ok);
      if (ok) begin
        @(posedge prog_clk); @(negedge prog_clk);
        if (i == poke) cfg_start = 1'b1;
      end
    end
    cfg_valid = 1'b0; cfg_data = '0;
    t = 0;
    while (done !== 1'b1 && t < 300) begin
      @(posedge prog_clk); @(negedge prog_clk);
      cfg_start = 1'b0;
      t++;
    end
    cfg_start = 1'b0;
    if (done === 1'b1) lat = cyc - start_cyc;
    else chk("done_timeout", done, 1);
    @(posedge prog_clk);
    sh_d = shifts_total - sh0;
    dn_d = dones_total - dn0;
    er_d = err_rise_at - sh0;
    @(negedge prog_clk);
  endtask

  int  lat, sh_d, dn_d, sh0, er_d, poke, fb;
  bit  exp_err;

  initial begin
    repeat (3) @(negedge prog_clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    #2 pReset = 1'b0;
    @(negedge prog_clk);

    // Reset while bit 5 of the first word is on the wire.
    cfg_start = 1'b1;
    @(posedge prog_clk); @(negedge prog_clk);
    cfg_start = 1'b0; cfg_data = 8'hA5; cfg_valid = 1'b1;
    @(posedge prog_clk); @(negedge prog_clk);
    cfg_valid = 1'b0;
    repeat (5) @(negedge prog_clk);
    chk("s1_bit5_head", ccff_head, 1);
    chk("s1_bit5_shift", shift_en, 1);
    #2 pReset = 1'b1;
    #1;
    chk("s1_busy", busy, 0);
    chk("s1_shift_en", shift_en, 0);
    chk("s1_head", ccff_head, 0);
    chk("s1_ready", cfg_ready, 0);
    chk("s1_done", done, 0);
    @(negedge prog_clk);
    #2 pReset = 1'b0;
    @(negedge prog_clk);

    for (int i = 0; i < MAXW; i++) begin
      seq_gap[i] = 0;
      seq_w[i] = (i % WPP == 0) ? 8'hA5 : (i % WPP == 1) ? 8'h3C : 8'hF9;
    end

`ifndef CCFF_READBACK_EN
    // Basic load with cfg_valid held high.
    run_seq(3, -1, lat, sh_d, dn_d, sh0, er_d);
    chk("s2_latency", lat, 23);
    chk("s2_shifts", sh_d, 20);
    chk("s2_dones", dn_d, 1);
    chk("s2_bits", log_vec(sh0), 32'h93CA5);

    // Seven-cycle stall before the second word.
    seq_gap[1] = 7;
    run_seq(3, -1, lat, sh_d, dn_d, sh0, er_d);
    chk("s3_latency", lat, 30);
    chk("s3_shifts", sh_d, 20);
    chk("s3_dones", dn_d, 1);
    chk("s3_bits", log_vec(sh0), 32'h93CA5);
    seq_gap[1] = 0;

    // cfg_start pulsed while shifting.
    run_seq(3, 0, lat, sh_d, dn_d, sh0, er_d);
    chk("s4_latency", lat, 23);
    chk("s4_shifts", sh_d, 20);
    chk("s4_dones", dn_d, 1);
    chk("s4_bits", log_vec(sh0), 32'h93CA5);
`else
    // Clean readback: identical bitstream twice.
    run_seq(6, -1, lat, sh_d, dn_d, sh0, er_d);
    chk("s5_latency", lat, 46);
    chk("s5_shifts", sh_d, 40);
    chk("s5_dones", dn_d, 1);
    chk("s5_bits_p1", log_vec(sh0), 32'h93CA5);
    chk("s5_bits_p2", log_vec(sh0 + 20), 32'h93CA5);
    chk("s5_err", cfg_err, 0);

    // Corrupted second-pass word 2.
    seq_w[4] = 8'h3D;
    run_seq(6, -1, lat, sh_d, dn_d, sh0, er_d);
    chk("s6_err_rise_shift", er_d, 29);
    chk("s6_shifts", sh_d, 40);
    chk("s6_dones", dn_d, 1);
    chk("s6_err_after_done", cfg_err, 1);
    seq_w[4] = 8'h3C;

    // Next start clears the flag.
    run_seq(6, -1, lat, sh_d, dn_d, sh0, er_d);
    chk("s6_err_cleared", cfg_err, 0);
    chk("s6b_shifts", sh_d, 40);
`endif

    // Randomised sequences: random words, stalls and stray start pulses.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < WPP; i++) seq_w[i] = WORD_W'($urandom);
      exp_err = 1'b0;
`ifdef CCFF_READBACK_EN
      for (int i = 0; i < WPP; i++) seq_w[WPP + i] = seq_w[i];
      if ($urandom_range(0, 1) == 1) begin
        fb = $urandom_range(0, CHAIN_LEN - 1);
        seq_w[WPP + fb / WORD_W][fb % WORD_W] = ~seq_w[WPP + fb / WORD_W][fb % WORD_W];
        exp_err = 1'b1;
      end
`endif
      for (int i = 0; i < MAXW; i++)
        seq_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      poke = int'($urandom_range(0, MAXW));
      if (poke == MAXW) poke = -1;
      run_seq(MAXW, poke, lat, sh_d, dn_d, sh0, er_d);
      chk("rnd_shifts", sh_d, CHAIN_LEN * NPASS);
      chk("rnd_dones", dn_d, 1);
      chk("rnd_bits_p1", log_vec(sh0), exp_vec(0));
`ifdef CCFF_READBACK_EN
      chk("rnd_bits_p2", log_vec(sh0 + CHAIN_LEN), exp_vec(1));
      chk("rnd_err", cfg_err, exp_err);
`else
      chk("rnd_err", cfg_err, exp_err);
`endif
    end

    repeat (2) @(negedge prog_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
